// File: rtl/mp_sram_pkg.sv
// Shared types and address helpers for the banked multi-port SRAM.
package mp_sram_pkg;

    localparam int unsigned MaxPorts = 16;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Banks are interleaved on the low address bits.
    function automatic int unsigned bank_sel(input int unsigned addr, input int unsigned num_banks);
        return addr & (num_banks - 1);
    endfunction

    function automatic int unsigned bank_row(input int unsigned addr, input int unsigned num_banks);
        return addr / num_banks;
    endfunction

endpackage

// File: rtl/mp_sram_bank_arb.sv
// Per-bank round-robin arbiter; the search starts at the pointer, which moves past each winner.
module mp_sram_bank_arb
    import mp_sram_pkg::*;
#(
    parameter int unsigned NumPorts = 4,
    localparam int unsigned IdxW    = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic [NumPorts-1:0] req_i,
    output logic [NumPorts-1:0] gnt_o,
    output logic [IdxW-1:0]     winner_o
);

    logic [IdxW-1:0] ptr_q, ptr_d;
    logic            found;
    int unsigned     idx;

    always_comb begin
        gnt_o    = '0;
        winner_o = '0;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            idx = (32'(ptr_q) + i) % NumPorts;
            if (!found && en_i && req_i[IdxW'(idx)]) begin
                found                = 1'b1;
                gnt_o[IdxW'(idx)]    = 1'b1;
                winner_o             = IdxW'(idx);
            end
        end
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = IdxW'((32'(winner_o) + 1) % NumPorts);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mp_sram_banked.sv
// Banked multi-port SRAM with per-bank round-robin arbitration and a post-reset clear sweep.
// Optional MP_SRAM_PERF_CNT_EN adds saturating per-port stall counters on stall_cnt_o.
module mp_sram_banked
    import mp_sram_pkg::*;
#(
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned NumWords    = 1024,
    parameter int unsigned NumPorts    = 4,
    parameter int unsigned NumBanks    = 4,
    parameter int unsigned ReadLatency = 1,
    localparam int unsigned AddrWidth  = $clog2(NumWords),
    localparam int unsigned BeWidth    = (DataWidth + 7) / 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NumPorts-1:0]            req_i,
    input  logic [NumPorts-1:0]            we_i,
    input  logic [NumPorts*AddrWidth-1:0]  addr_i,
    input  logic [NumPorts*DataWidth-1:0]  wdata_i,
    input  logic [NumPorts*BeWidth-1:0]    be_i,
    output logic [NumPorts-1:0]            gnt_o,
    output logic [NumPorts-1:0]            rvalid_o,
    output logic [NumPorts*DataWidth-1:0]  rdata_o,
    output logic                           init_done_o
`ifdef MP_SRAM_PERF_CNT_EN
    ,
    output logic [NumPorts*32-1:0]         stall_cnt_o
`endif
);

    localparam int unsigned RowsPerBank = NumWords / NumBanks;
    localparam int unsigned RowW        = (RowsPerBank > 1) ? $clog2(RowsPerBank) : 1;
    localparam int unsigned BankW       = (NumBanks > 1) ? $clog2(NumBanks) : 1;
    localparam int unsigned IdxW        = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    state_e           state_q, state_d;
    logic [RowW-1:0]  init_row_q, init_row_d;
    logic             init_done_q, init_done_d;
    logic             init_we;
    logic             arb_en;

    logic [AddrWidth-1:0] addr_a   [NumPorts];
    logic [DataWidth-1:0] wdata_a  [NumPorts];
    logic [BeWidth-1:0]   be_a     [NumPorts];
    logic [BankW-1:0]     port_bank[NumPorts];
    logic [RowW-1:0]      port_row [NumPorts];
    logic [NumPorts-1:0]  port_inr;

    logic [NumPorts-1:0]  bank_req  [NumBanks];
    logic [NumPorts-1:0]  bank_gnt  [NumBanks];
    logic [IdxW-1:0]      bank_win  [NumBanks];
    logic [NumBanks-1:0]  bank_we;
    logic [RowW-1:0]      bank_row_c[NumBanks];
    logic [DataWidth-1:0] bank_wdata[NumBanks];
    logic [DataWidth-1:0] bank_wmask[NumBanks];
    logic [DataWidth-1:0] bank_rdata[NumBanks];

    logic [DataWidth-1:0] mem [NumBanks][RowsPerBank];

    logic [NumPorts-1:0]  rd_fire;
    logic [NumPorts-1:0]  rvalid1_q, rvalid1_d;
    logic [DataWidth-1:0] rdata1_q [NumPorts];
    logic [DataWidth-1:0] rdata1_d [NumPorts];
    logic [NumPorts-1:0]  rvalid_out;
    logic [DataWidth-1:0] rdata_out[NumPorts];

    // Init sweep: one row of every bank cleared per cycle, then RUN.
    always_comb begin
        state_d     = state_q;
        init_row_d  = init_row_q;
        init_done_d = init_done_q;
        init_we     = 1'b0;
        case (state_q)
            INIT: begin
                init_we    = !rst_i;
                init_row_d = RowW'(init_row_q + 1'b1);
                if (init_row_q == RowW'(RowsPerBank - 1)) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                    init_row_d  = '0;
                end
            end
            RUN:     init_done_d = 1'b1;
            default: state_d     = INIT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= INIT;
            init_row_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_row_q  <= init_row_d;
            init_done_q <= init_done_d;
        end
    end

    assign init_done_o = init_done_q;
    assign arb_en      = (state_q == RUN) && !rst_i;

    always_comb begin
        for (int unsigned p = 0; p < NumPorts; p++) begin
            addr_a[p]    = addr_i[p*AddrWidth +: AddrWidth];
            wdata_a[p]   = wdata_i[p*DataWidth +: DataWidth];
            be_a[p]      = be_i[p*BeWidth +: BeWidth];
            port_bank[p] = BankW'(bank_sel(32'(addr_a[p]), NumBanks));
            port_row[p]  = RowW'(bank_row(32'(addr_a[p]), NumBanks));
            port_inr[p]  = 32'(addr_a[p]) < NumWords;
        end
        for (int unsigned b = 0; b < NumBanks; b++) begin
            for (int unsigned p = 0; p < NumPorts; p++) begin
                bank_req[b][p] = req_i[p] && (32'(port_bank[p]) == b);
            end
        end
    end

    for (genvar b = 0; b < NumBanks; b++) begin : g_bank
        mp_sram_bank_arb #(
            .NumPorts (NumPorts)
        ) u_arb (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .en_i     (arb_en),
            .req_i    (bank_req[b]),
            .gnt_o    (bank_gnt[b]),
            .winner_o (bank_win[b])
        );
    end

    // Each bank is steered by its winner; out-of-range words read 0 and ignore writes.
    always_comb begin
        gnt_o = '0;
        for (int unsigned b = 0; b < NumBanks; b++) begin
            gnt_o         = gnt_o | bank_gnt[b];
            bank_row_c[b] = port_row[bank_win[b]];
            bank_we[b]    = (|bank_gnt[b]) && we_i[bank_win[b]] && port_inr[bank_win[b]];
            bank_wdata[b] = wdata_a[bank_win[b]];
            for (int unsigned j = 0; j < DataWidth; j++) begin
                bank_wmask[b][j] = be_a[bank_win[b]][j/8];
            end
            bank_rdata[b] = port_inr[bank_win[b]] ? mem[b][bank_row_c[b]] : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned b = 0; b < NumBanks; b++) begin
            if (init_we) begin
                mem[b][init_row_q] <= '0;
            end else if (bank_we[b]) begin
                mem[b][bank_row_c[b]] <= (mem[b][bank_row_c[b]] & ~bank_wmask[b])
                                       | (bank_wdata[b] & bank_wmask[b]);
            end
        end
    end

    always_comb begin
        rd_fire   = gnt_o & ~we_i;
        rvalid1_d = rd_fire;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            rdata1_d[p] = rd_fire[p] ? bank_rdata[port_bank[p]] : rdata1_q[p];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid1_q <= '0;
            for (int unsigned p = 0; p < NumPorts; p++) begin
                rdata1_q[p] <= '0;
            end
        end else begin
            rvalid1_q <= rvalid1_d;
            rdata1_q  <= rdata1_d;
        end
    end

    if (ReadLatency == 2) begin : g_lat2
        logic [NumPorts-1:0]  rvalid2_q, rvalid2_d;
        logic [DataWidth-1:0] rdata2_q [NumPorts];
        logic [DataWidth-1:0] rdata2_d [NumPorts];

        always_comb begin
            rvalid2_d = rvalid1_q;
            for (int unsigned p = 0; p < NumPorts; p++) begin
                rdata2_d[p] = rvalid1_q[p] ? rdata1_q[p] : rdata2_q[p];
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                rvalid2_q <= '0;
                for (int unsigned p = 0; p < NumPorts; p++) begin
                    rdata2_q[p] <= '0;
                end
            end else begin
                rvalid2_q <= rvalid2_d;
                rdata2_q  <= rdata2_d;
            end
        end

        assign rvalid_out = rvalid2_q;
        assign rdata_out  = rdata2_q;
    end else begin : g_lat1
        assign rvalid_out = rvalid1_q;
        assign rdata_out  = rdata1_q;
    end

    always_comb begin
        rvalid_o = rvalid_out;
        rdata_o  = '0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            rdata_o[p*DataWidth +: DataWidth] = rdata_out[p];
        end
    end

`ifdef MP_SRAM_PERF_CNT_EN
    logic [31:0] stall_q [NumPorts];
    logic [31:0] stall_d [NumPorts];

    // Saturating count of RUN cycles a port requested but lost arbitration.
    always_comb begin
        stall_cnt_o = '0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            stall_d[p] = stall_q[p];
            if ((state_q == RUN) && req_i[p] && !gnt_o[p] && (stall_q[p] != '1)) begin
                stall_d[p] = stall_q[p] + 32'd1;
            end
            stall_cnt_o[p*32 +: 32] = stall_q[p];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned p = 0; p < NumPorts; p++) begin
                stall_q[p] <= '0;
            end
        end else begin
            stall_q <= stall_d;
        end
    end
`endif

endmodule
